kronos_ex_opfwd: RTL and testbench

// Operand resolution stage between ID/EX handoff and the EX ALU. Registers decoded operands plus per-operand hazard flags,

---
 rtl/kronos_ex_opfwd.sv | 167 ++++++++++++++++
 tb/tb_kronos_ex_opfwd.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kronos_ex_opfwd.sv
// Operand resolution stage between ID/EX handoff and the EX ALU.
// Holds a captured instruction until its hazards clear, substitutes forwarded write-back data, then presents it under valid/ready.
`timescale 1ns/1ps
module kronos_ex_opfwd #(
  parameter int PAYLOAD_W   = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   id_vld,
  output logic                   id_rdy,
  input  logic [31:0]            id_op1,
  input  logic [31:0]            id_op2,
  input  logic [31:0]            id_op3,
  input  logic [31:0]            id_op4,
  input  logic [PAYLOAD_W-1:0]   id_payload,
  input  logic                   hz_op1,
  input  logic                   hz_op2,
  input  logic                   hz_op3,
  input  logic                   hz_op4,
  input  logic                   hz_any,
  input  logic                   fwd_vld,
  input  logic [31:0]            fwd_data,
  output logic                   ex_vld,
  input  logic                   ex_rdy,
  output logic [31:0]            ex_op1,
  output logic [31:0]            ex_op2,
  output logic [31:0]            ex_op3,
  output logic [31:0]            ex_op4,
  output logic [PAYLOAD_W-1:0]   ex_payload,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    VALID = 2'd2
  } state_t;

  localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STALL_CNT_W-1:0] STALL_MAX = {STALL_CNT_W{1'b1}};

  state_t                   state_r, state_s;
  logic                     first_r, first_s;
  logic [3:0]               flags_r, flags_s;
  logic [3:0][31:0]         op_r, op_s;
  logic [PAYLOAD_W-1:0]     payload_r, payload_s;
  logic [STALL_CNT_W-1:0]   stall_r, stall_s;
  logic                     ex_vld_r, ex_vld_s;
  logic [3:0]               hz_vec_s;
  logic [3:0]               cur_flags_s;
  logic                     hz_open_s;
  logic [3:0][31:0]         id_op_s;

  assign hz_vec_s = {hz_op4, hz_op3, hz_op2, hz_op1};
  assign id_op_s  = {id_op4, id_op3, id_op2, id_op1};

  // The first HOLD cycle takes flags straight from the hazard unit; later cycles use the latched copy.
  assign cur_flags_s = first_r ? hz_vec_s : flags_r;
  assign hz_open_s   = first_r ? hz_any   : (|flags_r);

  assign id_rdy = (state_r == IDLE) | ((state_r == VALID) & ex_rdy);

  // Next-state, operand substitution and stall counting.
  always_comb begin
    state_s   = state_r;
    first_s   = 1'b0;
    flags_s   = flags_r;
    op_s      = op_r;
    payload_s = payload_r;
    stall_s   = stall_r;

    if ((state_r == HOLD) && hz_open_s && !fwd_vld && (stall_r != STALL_MAX)) begin
      stall_s = stall_r + STALL_ONE;
    end else begin
      stall_s = stall_r;
    end

    if (flush) begin
      state_s = IDLE;
      flags_s = 4'b0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (id_vld) begin
            state_s   = HOLD;
            first_s   = 1'b1;
            flags_s   = 4'b0000;
            op_s      = id_op_s;
            payload_s = id_payload;
          end else begin
            state_s = IDLE;
          end
        end
        HOLD: begin
          if (!hz_open_s) begin
            state_s = VALID;
            flags_s = 4'b0000;
          end else if (fwd_vld) begin
            for (int i = 0; i < 4; i++) begin
              if (cur_flags_s[i]) begin
                op_s[i] = fwd_data;
              end else begin
                op_s[i] = op_r[i];
              end
            end
            flags_s = 4'b0000;
            state_s = VALID;
          end else begin
            flags_s = cur_flags_s;
            state_s = HOLD;
          end
        end
        VALID: begin
          if (ex_rdy && id_vld) begin
            state_s   = HOLD;
            first_s   = 1'b1;
            flags_s   = 4'b0000;
            op_s      = id_op_s;
            payload_s = id_payload;
          end else if (ex_rdy) begin
            state_s = IDLE;
          end else begin
            state_s = VALID;
          end
        end
        default: begin
          state_s = IDLE;
          flags_s = 4'b0000;
        end
      endcase
    end

    ex_vld_s = (state_s == VALID);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      first_r   <= 1'b0;
      flags_r   <= 4'b0000;
      op_r      <= '0;
      payload_r <= {PAYLOAD_W{1'b0}};
      stall_r   <= {STALL_CNT_W{1'b0}};
      ex_vld_r  <= 1'b0;
    end else begin
      state_r   <= state_s;
      first_r   <= first_s;
      flags_r   <= flags_s;
      op_r      <= op_s;
      payload_r <= payload_s;
      stall_r   <= stall_s;
      ex_vld_r  <= ex_vld_s;
    end
  end

  assign ex_vld     = ex_vld_r;
  assign ex_op1     = op_r[0];
  assign ex_op2     = op_r[1];
  assign ex_op3     = op_r[2];
  assign ex_op4     = op_r[3];
  assign ex_payload = payload_r;
  assign stall_cnt  = stall_r;

endmodule

// File: tb/tb_kronos_ex_opfwd.sv
// Bench for kronos_ex_opfwd: directed scenarios plus randomized traffic checked against a transaction-level model.
`timescale 1ns/1ps
module tb_kronos_ex_opfwd;

  localparam int PW   = 32;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          id_vld;
  logic          id_rdy;
  logic [31:0]   id_ops [4];
  logic [PW-1:0] id_payload;
  logic [3:0]    hz_v;
  logic          fwd_vld;
  logic [31:0]   fwd_data;
  logic          ex_vld;
  logic          ex_rdy;
  logic [31:0]   ex_op1, ex_op2, ex_op3, ex_op4;
  logic [PW-1:0] ex_payload;
  logic [SW-1:0] stall_cnt;

  always #5 clk = ~clk;

  kronos_ex_opfwd #(.PAYLOAD_W(PW), .STALL_CNT_W(SW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .id_vld(id_vld), .id_rdy(id_rdy),
    .id_op1(id_ops[0]), .id_op2(id_ops[1]), .id_op3(id_ops[2]), .id_op4(id_ops[3]),
    .id_payload(id_payload),
    .hz_op1(hz_v[0]), .hz_op2(hz_v[1]), .hz_op3(hz_v[2]), .hz_op4(hz_v[3]), .hz_any(|hz_v),
    .fwd_vld(fwd_vld), .fwd_data(fwd_data),
    .ex_vld(ex_vld), .ex_rdy(ex_rdy),
    .ex_op1(ex_op1), .ex_op2(ex_op2), .ex_op3(ex_op3), .ex_op4(ex_op4),
    .ex_payload(ex_payload), .stall_cnt(stall_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Reference model: one instruction slot tracked by what has happened to it since capture.
  bit          m_has, m_ready;
  int          m_age;
  logic [3:0]  m_mask;
  logic [31:0] m_ops [4];
  logic [31:0] m_pay;
  int          m_stall;

  task automatic model_reset();
    m_has = 1'b0; m_ready = 1'b0; m_age = 0; m_mask = 4'b0000;
    for (int i = 0; i < 4; i++) m_ops[i] = 32'd0;
    m_pay = 32'd0; m_stall = 0;
  endtask

  function automatic bit model_rdy();
    return !m_has || (m_ready && ex_rdy);
  endfunction

  task automatic model_capture();
    for (int i = 0; i < 4; i++) m_ops[i] = id_ops[i];
    m_pay = id_payload; m_has = 1'b1; m_ready = 1'b0; m_age = 0; m_mask = 4'b0000;
  endtask

  task automatic model_step();
    logic [3:0] cur;
    bit open;
    cur  = (m_age == 0) ? hz_v : m_mask;
    open = (cur != 4'b0000);
    if (m_has && !m_ready && open && !fwd_vld) m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
    if (flush) begin
      m_has = 1'b0; m_ready = 1'b0; m_mask = 4'b0000;
    end else if (m_has && !m_ready) begin
      if (!open) m_ready = 1'b1;
      else if (fwd_vld) begin
        for (int i = 0; i < 4; i++) if (cur[i]) m_ops[i] = fwd_data;
        m_mask = 4'b0000; m_ready = 1'b1;
      end else begin
        m_mask = cur; m_age++;
      end
    end else if (m_has && m_ready) begin
      if (ex_rdy) begin
        if (id_vld) model_capture();
        else begin m_has = 1'b0; m_ready = 1'b0; end
      end
    end else if (id_vld) begin
      model_capture();
    end
  endtask

  task automatic check_outs();
    check("ex_vld", {31'd0, ex_vld}, {31'd0, (m_has && m_ready)});
    check("ex_op1", ex_op1, m_ops[0]);
    check("ex_op2", ex_op2, m_ops[1]);
    check("ex_op3", ex_op3, m_ops[2]);
    check("ex_op4", ex_op4, m_ops[3]);
    check("ex_payload", ex_payload, m_pay);
    check("stall_cnt", {28'd0, stall_cnt}, m_stall);
  endtask

  // One clock: combinational ready check, edge, then registered outputs on the falling edge.
  task automatic cycle();
    #1;
    check("id_rdy", {31'd0, id_rdy}, {31'd0, model_rdy()});
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outs();
  endtask

  task automatic set_idle();
    id_vld = 1'b0; flush = 1'b0; fwd_vld = 1'b0; ex_rdy = 1'b1; hz_v = 4'b0000;
    fwd_data = 32'd0; id_payload = 32'd0;
    for (int i = 0; i < 4; i++) id_ops[i] = 32'd0;
  endtask

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] c, input logic [31:0] d);
    id_ops[0] = a; id_ops[1] = b; id_ops[2] = c; id_ops[3] = d;
    id_payload = a ^ 32'h5A5A_0000;
  endtask

  initial begin
    set_idle();
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ex_vld", {31'd0, ex_vld}, 32'd0);
    check("rst_ex_op1", ex_op1, 32'd0);
    check("rst_stall", {28'd0, stall_cnt}, 32'd0);
    check("rst_id_rdy", {31'd0, id_rdy}, 32'd1);
    rst = 1'b0;

    // No hazard: two cycles to ex_vld.
    id_vld = 1'b1; set_ops(32'h11, 32'h22, 32'h33, 32'h44);
    cycle();
    check("t1_lat", {31'd0, ex_vld}, 32'd0);
    id_vld = 1'b0;
    cycle();
    check("t1_vld", {31'd0, ex_vld}, 32'd1);
    check("t1_op1", ex_op1, 32'h11);
    check("t1_op2", ex_op2, 32'h22);
    check("t1_stall", {28'd0, stall_cnt}, 32'd0);

    // RAW hazard on op1, forwarded after three stall cycles.
    id_vld = 1'b1; set_ops(32'h100, 32'h200, 32'h300, 32'h400);
    cycle();
    id_vld = 1'b0; hz_v = 4'b0001;
    cycle();
    hz_v = 4'b0000;
    cycle();
    cycle();
    check("t2_hold_rdy", {31'd0, id_rdy}, 32'd0);
    fwd_vld = 1'b1; fwd_data = 32'hDEADBEEF; ex_rdy = 1'b0;
    cycle();
    check("t2_vld", {31'd0, ex_vld}, 32'd1);
    check("t2_op1", ex_op1, 32'hDEADBEEF);
    check("t2_op2", ex_op2, 32'h200);
    check("t2_stall", {28'd0, stall_cnt}, 32'd3);

    // Backpressure, then retire and capture on the same edge.
    fwd_vld = 1'b0; id_vld = 1'b1; set_ops(32'hA, 32'hB, 32'hC, 32'hD);
    for (int k = 0; k < 4; k++) begin
      cycle();
      check("t3_stable", ex_op1, 32'hDEADBEEF);
      check("t3_rdy", {31'd0, id_rdy}, 32'd0);
    end
    ex_rdy = 1'b1; set_ops(32'h333, 32'h444, 32'h555, 32'h666);
    cycle();
    check("t3_b2b_vld", {31'd0, ex_vld}, 32'd0);
    check("t3_b2b_op1", ex_op1, 32'h333);

    // Flush in HOLD, then a stray forward must not alter operands.
    id_vld = 1'b0; hz_v = 4'b0010;
    cycle();
    hz_v = 4'b0000; flush = 1'b1;
    cycle();
    flush = 1'b0; fwd_vld = 1'b1; fwd_data = 32'h55;
    #1;
    check("t4_rdy", {31'd0, id_rdy}, 32'd1);
    cycle();
    check("t4_vld", {31'd0, ex_vld}, 32'd0);
    check("t4_op2", ex_op2, 32'h444);

    // Flush in VALID.
    fwd_vld = 1'b0; id_vld = 1'b1; ex_rdy = 1'b0; set_ops(32'h7, 32'h8, 32'h9, 32'hA);
    cycle();
    id_vld = 1'b0;
    cycle();
    check("t4v_vld", {31'd0, ex_vld}, 32'd1);
    flush = 1'b1;
    cycle();
    check("t4v_flush", {31'd0, ex_vld}, 32'd0);
    flush = 1'b0; fwd_vld = 1'b1; fwd_data = 32'h66;
    cycle();
    check("t4v_op1", ex_op1, 32'h7);

    // Randomized traffic against the model.
    for (int k = 0; k < 2000; k++) begin
      id_vld   = ($urandom_range(0, 9) < 6);
      ex_rdy   = ($urandom_range(0, 9) < 6);
      fwd_vld  = ($urandom_range(0, 9) < 3);
      flush    = ($urandom_range(0, 19) == 0);
      for (int i = 0; i < 4; i++) begin
        hz_v[i]   = ($urandom_range(0, 9) < 3);
        id_ops[i] = $urandom;
      end
      id_payload = $urandom;
      fwd_data   = $urandom;
      cycle();
    end

    // Saturation with a fresh counter.
    set_idle();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    id_vld = 1'b1; set_ops(32'h1, 32'h2, 32'h3, 32'h4);
    cycle();
    id_vld = 1'b0; hz_v = 4'b1001;
    cycle();
    hz_v = 4'b0000;
    for (int k = 0; k < 19; k++) cycle();
    check("t5_sat", {28'd0, stall_cnt}, 32'd15);
    cycle();
    check("t5_sat_hold", {28'd0, stall_cnt}, 32'd15);

    // Asynchronous reset while holding.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_arst_vld", {31'd0, ex_vld}, 32'd0);
    check("t5_arst_op1", ex_op1, 32'd0);
    check("t5_arst_op4", ex_op4, 32'd0);
    check("t5_arst_pay", ex_payload, 32'd0);
    check("t5_arst_stall", {28'd0, stall_cnt}, 32'd0);
    check("t5_arst_rdy", {31'd0, id_rdy}, 32'd1);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
